// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared types and constants for the MEM-stage load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      LOAD  = 2'b01,
      STORE = 2'b10
   } mem_op_e;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } data_type_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } lsu_state_e;

   localparam int LSU_CNT_W = 8;

   // Size code 2'b11 behaves as a word everywhere.
   function automatic logic is_misaligned(input logic [1:0] dtype, input logic [1:0] lo);
      if (dtype == HALF) return lo[0];
      if (dtype[1])      return |lo;
      return 1'b0;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// rtl/mem_stage_lsu_align.sv - combinational store lane replication, byte enables and load lane select/extend
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_lo,
   input  logic [1:0]  st_type,
   input  logic [31:0] st_data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   input  logic [1:0]  ld_lo,
   input  logic [1:0]  ld_type,
   input  logic        ld_unsigned,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      wdata = st_data;
      be    = 4'b1111;
      if (st_type == BYTE) begin
         wdata = {4{st_data[7:0]}};
         be    = 4'b0001 << st_lo;
      end else if (st_type == HALF) begin
         wdata = {2{st_data[15:0]}};
         be    = 4'b0011 << {st_lo[1], 1'b0};
      end
   end

   always_comb begin
      case (ld_lo)
         2'd0:    ld_byte = rdata[7:0];
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         default: ld_byte = rdata[31:24];
      endcase
      ld_half = ld_lo[1] ? rdata[31:16] : rdata[15:0];

      ld_data = rdata;
      if (ld_type == BYTE)
         ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      else if (ld_type == HALF)
         ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: request/ack FSM, wait timeout, stall generation
// Optional misaligned-access trap when LSU_MISALIGN_TRAP_EN is defined.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_alu_dataM,
   input  logic [31:0] i_rs2_dataM,
   input  logic [1:0]  i_mem_wrenM,
   input  logic [1:0]  i_data_typeM,
   input  logic        i_unsignedM,
   input  logic        i_hold,
   output logic        o_stallM,
   output logic        o_req,
   output logic        o_we,
   output logic [31:0] o_addr,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   input  logic        i_ack,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_dataM,
   output logic        o_ld_validM,
   output logic        o_misalignedM,
   output logic        o_bus_errM
);

   localparam logic [LSU_CNT_W-1:0] WAIT_LAST = LSU_CNT_W'(MAX_WAIT - 1);

   lsu_state_e             state_q, state_d;
   logic [LSU_CNT_W-1:0]   cnt_q;
   logic                   err_q, is_load_q, uns_q;
   logic [1:0]             lo_q, type_q;
   logic                   access, go;
   logic [1:0]             eff_lo;
   logic [31:0]            wdata_c, ld_fmt;
   logic [3:0]             be_c;

   assign access = (state_q == IDLE) &&
                   ((i_mem_wrenM == LOAD) || (i_mem_wrenM == STORE));

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis;
   assign mis           = is_misaligned(i_data_typeM, i_alu_dataM[1:0]);
   assign go            = access && !mis;
   assign o_misalignedM = access && mis;
   assign eff_lo        = i_alu_dataM[1:0];
`else
   // Without the trap, misaligned halves/words are silently aligned down.
   assign go            = access;
   assign o_misalignedM = 1'b0;
   assign eff_lo        = (i_data_typeM == BYTE) ? i_alu_dataM[1:0] :
                          (i_data_typeM == HALF) ? {i_alu_dataM[1], 1'b0} : 2'b00;
`endif

   assign o_stallM    = go || (state_q == BUSY);
   assign o_req       = (state_q == BUSY);
   assign o_ld_validM = (state_q == DONE) && is_load_q;
   assign o_bus_errM  = (state_q == DONE) && err_q;

   lsu_align u_align (
      .st_lo       (eff_lo),
      .st_type     (i_data_typeM),
      .st_data     (i_rs2_dataM),
      .wdata       (wdata_c),
      .be          (be_c),
      .ld_lo       (lo_q),
      .ld_type     (type_q),
      .ld_unsigned (uns_q),
      .rdata       (i_rdata),
      .ld_data     (ld_fmt)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = BUSY;
         BUSY:    if (i_ack || (cnt_q == WAIT_LAST)) state_d = DONE;
         DONE:    if (!i_hold) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q      <= '0;
         err_q      <= 1'b0;
         is_load_q  <= 1'b0;
         uns_q      <= 1'b0;
         lo_q       <= 2'b00;
         type_q     <= 2'b00;
         o_addr     <= '0;
         o_be       <= '0;
         o_we       <= 1'b0;
         o_wdata    <= '0;
         o_ld_dataM <= '0;
      end else begin
         case (state_q)
            IDLE: if (go) begin
               o_addr     <= {i_alu_dataM[31:2], 2'b00};
               o_be       <= be_c;
               o_we       <= (i_mem_wrenM == STORE);
               o_wdata    <= wdata_c;
               cnt_q      <= '0;
               err_q      <= 1'b0;
               o_ld_dataM <= '0;
               is_load_q  <= (i_mem_wrenM == LOAD);
               lo_q       <= eff_lo;
               type_q     <= i_data_typeM;
               uns_q      <= i_unsignedM;
            end
            BUSY: begin
               cnt_q <= cnt_q + 1'b1;
               if (i_ack) begin
                  if (is_load_q) o_ld_dataM <= ld_fmt;
               end else if (cnt_q == WAIT_LAST) begin
                  err_q      <= 1'b1;
                  o_ld_dataM <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu (MAX_WAIT = 4)
module tb_mem_stage_lsu;

   localparam int MAXW = 4;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_alu_dataM, i_rs2_dataM, i_rdata;
   logic [1:0]  i_mem_wrenM, i_data_typeM;
   logic        i_unsignedM, i_hold, i_ack;
   logic        o_stallM, o_req, o_we, o_ld_validM, o_misalignedM, o_bus_errM;
   logic [31:0] o_addr, o_wdata, o_ld_dataM;
   logic [3:0]  o_be;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] ld;
      logic [3:0]  be;
      logic        we;
      logic        valid;
      logic        err;
      int          stall;
      int          req;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   mem_stage_lsu #(.MAX_WAIT(MAXW)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_alu_dataM   (i_alu_dataM),
      .i_rs2_dataM   (i_rs2_dataM),
      .i_mem_wrenM   (i_mem_wrenM),
      .i_data_typeM  (i_data_typeM),
      .i_unsignedM   (i_unsignedM),
      .i_hold        (i_hold),
      .o_stallM      (o_stallM),
      .o_req         (o_req),
      .o_we          (o_we),
      .o_addr        (o_addr),
      .o_be          (o_be),
      .o_wdata       (o_wdata),
      .i_ack         (i_ack),
      .i_rdata       (i_rdata),
      .o_ld_dataM    (o_ld_dataM),
      .o_ld_validM   (o_ld_validM),
      .o_misalignedM (o_misalignedM),
      .o_bus_errM    (o_bus_errM)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [1:0] dt, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] rs2,
                                  input logic [31:0] rdata, input int waits, input bit ack_en);
      exp_t        e;
      int          sz, lane;
      logic [31:0] base, sh;
      sz   = (dt == 2'b00) ? 1 : (dt == 2'b01) ? 2 : 4;
      base = addr & ~(32'(sz - 1));
      lane = int'(base[1:0]);
      e.addr = {base[31:2], 2'b00};
      e.be   = 4'(((1 << sz) - 1) << lane);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rs2[8*(i % sz) +: 8];
      e.we = (op == 2'b10);
      sh   = rdata >> (8 * lane);
      if (sz == 4)      e.ld = sh;
      else if (sz == 2) e.ld = {{16{!uns && sh[15]}}, sh[15:0]};
      else              e.ld = {{24{!uns && sh[7]}}, sh[7:0]};
      if (op != 2'b01 || !ack_en) e.ld = 32'h0;
      e.valid = (op == 2'b01);
      e.err   = !ack_en;
      e.stall = ack_en ? waits + 2 : MAXW + 1;
      e.req   = ack_en ? waits + 1 : MAXW;
      return e;
   endfunction

   task automatic run_access(input logic [1:0] op, input logic [1:0] dt, input logic uns,
                             input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [31:0] rdata, input int waits, input bit ack_en,
                             input int hold_n);
      exp_t e;
      int   stall_n, req_n, cyc;
      bit   done;
      sb.push_back(model(op, dt, uns, addr, rs2, rdata, waits, ack_en));
      stall_n = 0; req_n = 0; cyc = 0; done = 0;
      @(negedge i_clk);
      i_mem_wrenM = op; i_data_typeM = dt; i_unsignedM = uns;
      i_alu_dataM = addr; i_rs2_dataM = rs2; i_hold = 1'b0;
      while (!done && cyc < 64) begin
         #1;
         if (cyc == 0) check("idle_misaligned", 32'(o_misalignedM), 32'h0);
         if (o_stallM) stall_n++;
         if (o_req) begin
            req_n++;
            check("bus_addr",  o_addr,         sb[0].addr);
            check("bus_be",    32'(o_be),      32'(sb[0].be));
            check("bus_we",    32'(o_we),      32'(sb[0].we));
            check("bus_wdata", o_wdata,        sb[0].wdata);
            i_ack   = ack_en && (req_n == waits + 1);
            i_rdata = i_ack ? rdata : ~rdata;
         end else begin
            i_ack = 1'b0;
            if (req_n > 0) done = 1;
         end
         if (!done) begin
            @(negedge i_clk);
            cyc++;
         end
      end
      check("done_reached", 32'(done), 32'h1);
      i_mem_wrenM = 2'b00;
      i_ack = 1'b0;
      e = sb.pop_front();
      check("ld_data",  o_ld_dataM,         e.ld);
      check("ld_valid", 32'(o_ld_validM),   32'(e.valid));
      check("bus_err",  32'(o_bus_errM),    32'(e.err));
      check("stall_n",  32'(stall_n),       32'(e.stall));
      check("req_n",    32'(req_n),         32'(e.req));
      i_hold = (hold_n > 0);
      for (int k = 0; k < hold_n; k++) begin
         @(negedge i_clk);
         #1;
         check("hold_valid", 32'(o_ld_validM), 32'(e.valid));
         check("hold_data",  o_ld_dataM,       e.ld);
         check("hold_req",   32'(o_req),       32'h0);
         if (k == hold_n - 1) i_hold = 1'b0;
      end
      @(negedge i_clk);
      #1;
      check("back_idle_valid", 32'(o_ld_validM), 32'h0);
      check("back_idle_err",   32'(o_bus_errM),  32'h0);
      check("back_idle_req",   32'(o_req),       32'h0);
      check("back_idle_stall", 32'(o_stallM),    32'h0);
   endtask

   initial begin
      logic [1:0]  rop, rdt;
      logic [31:0] raddr;
      i_rst = 1'b1; i_alu_dataM = '0; i_rs2_dataM = '0; i_rdata = '0;
      i_mem_wrenM = '0; i_data_typeM = '0; i_unsignedM = 1'b0; i_hold = 1'b0; i_ack = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_req",   32'(o_req),         32'h0);
      check("rst_stall", 32'(o_stallM),      32'h0);
      check("rst_we",    32'(o_we),          32'h0);
      check("rst_addr",  o_addr,             32'h0);
      check("rst_be",    32'(o_be),          32'h0);
      check("rst_wdata", o_wdata,            32'h0);
      check("rst_ld",    o_ld_dataM,         32'h0);
      check("rst_valid", 32'(o_ld_validM),   32'h0);
      check("rst_mis",   32'(o_misalignedM), 32'h0);
      check("rst_err",   32'(o_bus_errM),    32'h0);
      i_rst = 1'b0;

      // LB signed, zero-wait
      run_access(2'b01, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1, 0);
      // SH, 3 wait cycles (ack on the last BUSY cycle before timeout)
      run_access(2'b10, 2'b01, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0, 3, 1, 0);
      // LHU
      run_access(2'b01, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 1, 0);
      // LW timeout
      run_access(2'b01, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 0, 0);
      // LBU held in DONE for 3 cycles
      run_access(2'b01, 2'b00, 1'b1, 32'h0000_0011, 32'h0, 32'h0000_AB00, 1, 1, 3);
      // SB and LH signed
      run_access(2'b10, 2'b00, 1'b0, 32'h0000_0305, 32'h0000_005A, 32'h0, 2, 1, 0);
      run_access(2'b01, 2'b01, 1'b0, 32'h0000_0306, 32'h0, 32'hC3A5_0000, 1, 1, 0);

      for (int n = 0; n < 6; n++) begin
         rop   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         rdt   = 2'($urandom_range(0, 2));
         raddr = $urandom;
         if (rdt == 2'b01) raddr[0] = 1'b0;
         if (rdt == 2'b10) raddr[1:0] = 2'b00;
         run_access(rop, rdt, 1'($urandom_range(0, 1)), raddr, $urandom, $urandom,
                    $urandom_range(0, MAXW - 1), 1, 0);
      end

`ifdef LSU_MISALIGN_TRAP_EN
      @(negedge i_clk);
      i_mem_wrenM = 2'b01; i_data_typeM = 2'b10; i_alu_dataM = 32'h0000_0041;
      #1;
      check("mis_flag",  32'(o_misalignedM), 32'h1);
      check("mis_stall", 32'(o_stallM),      32'h0);
      check("mis_req",   32'(o_req),         32'h0);
      @(negedge i_clk);
      i_mem_wrenM = 2'b00;
      #1;
      check("mis_req_after", 32'(o_req),         32'h0);
      check("mis_flag_off",  32'(o_misalignedM), 32'h0);
`else
      run_access(2'b01, 2'b10, 1'b0, 32'h0000_0041, 32'h0, 32'h0BAD_F00D, 0, 1, 0);
`endif

      // ack while idle is ignored
      @(negedge i_clk);
      i_ack = 1'b1; i_rdata = 32'hFFFF_FFFF;
      #1;
      check("idle_ack_req", 32'(o_req), 32'h0);
      @(negedge i_clk);
      i_ack = 1'b0;
      #1;
      check("idle_ack_req2",   32'(o_req),       32'h0);
      check("idle_ack_valid",  32'(o_ld_validM), 32'h0);

      // reset in the middle of BUSY
      @(negedge i_clk);
      i_mem_wrenM = 2'b01; i_data_typeM = 2'b10; i_alu_dataM = 32'h0000_0080;
      @(negedge i_clk);
      #1;
      check("pre_rst_req", 32'(o_req), 32'h1);
      i_mem_wrenM = 2'b00;
      i_rst = 1'b1;
      #1;
      check("rst_async_req",   32'(o_req),    32'h0);
      check("rst_async_stall", 32'(o_stallM), 32'h0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      #1;
      check("post_rst_req",   32'(o_req),       32'h0);
      check("post_rst_valid", 32'(o_ld_validM), 32'h0);
      run_access(2'b01, 2'b10, 1'b0, 32'h0000_0084, 32'h0, 32'h7654_3210, 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
